// File: rtl/uart_pkg.sv
// uart_pkg: oversampling constants and rx state encodings shared by the UART receiver and the future transmitter
package uart_pkg;
    localparam int OVERSAMPLE = 16;
    localparam int TICK_W     = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(7);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: multi-stage synchroniser for the asynchronous rx line, resets to the idle-high level
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_ff;
    // shift the raw line through the flop chain; reset to 1 so a reset never looks like a start bit
    always_ff @(posedge clk) r_ff <= rst ? '1 : {r_ff[STAGES-2:0], i_d};
    assign o_q = r_ff[STAGES-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver, LSB first; define UART_PARITY_EN for an even-parity bit
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud16x_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 rx_busy
);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);
    logic                 w_rx_s;
    rx_state_t            r_state;
    logic [TICK_W-1:0]    r_tick_cnt;
    logic [2:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shreg;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
`ifdef UART_PARITY_EN
    logic                 r_par_bit;
    logic                 r_parity_err;
`endif

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx_s)
    );

    // frame FSM: advances on baud ticks only, while the result pulses clear every clk
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RX_IDLE;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shreg      <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            if (baud16x_tick) begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
                case (r_state)
                    RX_IDLE: begin
                        if (!w_rx_s) begin
                            r_state    <= RX_START;
                            r_tick_cnt <= '0;
                        end
                    end
                    RX_START: begin
                        if (r_tick_cnt == MID_TICK) begin
                            r_state    <= w_rx_s ? RX_IDLE : RX_DATA;
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                        end
                    end
                    RX_DATA: begin
                        if (r_tick_cnt == LAST_TICK) begin
                            r_shreg   <= {w_rx_s, r_shreg[DATA_BITS-1:1]};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
`ifdef UART_PARITY_EN
                            if (r_bit_cnt == BIT_LAST) r_state <= RX_PARITY;
`else
                            if (r_bit_cnt == BIT_LAST) r_state <= RX_STOP;
`endif
                        end
                    end
`ifdef UART_PARITY_EN
                    RX_PARITY: begin
                        if (r_tick_cnt == LAST_TICK) begin
                            r_par_bit <= w_rx_s;
                            r_state   <= RX_STOP;
                        end
                    end
`endif
                    RX_STOP: begin
                        if (r_tick_cnt == LAST_TICK) begin
                            if (w_rx_s) begin
                                r_rx_data    <= r_shreg;
                                r_rx_valid   <= 1'b1;
`ifdef UART_PARITY_EN
                                r_parity_err <= ^{r_shreg, r_par_bit};
`endif
                                r_state      <= RX_IDLE;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= RX_BREAK;
                            end
                        end
                    end
                    RX_BREAK: begin
                        if (w_rx_s) r_state <= RX_IDLE;
                    end
                    default: r_state <= RX_IDLE;
                endcase
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign rx_busy   = (r_state != RX_IDLE);
`ifdef UART_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx (tick every 4th clk, 64 clk per bit); honours UART_PARITY_EN
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       rx_busy;
    logic [1:0] tdiv = 2'd0;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
    } exp_t;
    exp_t q[$];
    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;
    int n_fe     = 0;

    uart_rx #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .baud16x_tick (tick),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .frame_err    (frame_err),
        .parity_err   (parity_err),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    // one-clk tick every 4th clk, changed on the falling edge
    always @(negedge clk) begin
        tdiv = tdiv + 2'd1;
        tick = (tdiv == 2'd0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (64) @(negedge clk);
    endtask

    // drive one frame; a good stop bit queues the expected byte and parity flag
    task automatic send(input logic [7:0] d, input logic stop_b, input logic par_flip);
        if (stop_b) q.push_back({d, par_flip});
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_PARITY_EN
        bit_time((^d) ^ par_flip);
`endif
        bit_time(stop_b);
        rx = 1'b1;
    endtask

    // scoreboard: compare every valid strobe against the oldest queued frame
    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            chk("sb_nonempty", q.size() > 0, 1);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("rx_data", rx_data, e.d);
                chk("parity_err", parity_err, e.pe);
            end
        end
        if (parity_err) chk("perr_with_valid", rx_valid, 1);
        if (frame_err) n_fe++;
    end

    initial begin
        int fe0, v0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_data", rx_data, 0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_fe", frame_err, 0);
        chk("rst_pe", parity_err, 0);
        chk("rst_busy", rx_busy, 0);
        repeat (64) @(negedge clk);

        send(8'hA5, 1'b1, 1'b0);
        repeat (64) @(negedge clk);
        chk("t1_busy", rx_busy, 0);
        chk("t1_valid_cnt", n_valid, 1);
        chk("t1_fe_cnt", n_fe, 0);

        send(8'h00, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        repeat (64) @(negedge clk);
        chk("t2_valid_cnt", n_valid, 3);
        chk("t2_busy", rx_busy, 0);

        v0 = n_valid;
        rx = 1'b0;
        repeat (12) @(negedge clk);
        chk("t3_busy_start", rx_busy, 1);
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        chk("t3_busy_idle", rx_busy, 0);
        chk("t3_no_valid", n_valid, v0);

        fe0 = n_fe;
        send(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (5 * 64) @(negedge clk);
        chk("t4_fe_once", n_fe, fe0 + 1);
        chk("t4_break_busy", rx_busy, 1);
        chk("t4_no_valid", n_valid, v0);
        chk("t4_data_kept", rx_data, 8'hFF);
        rx = 1'b1;
        repeat (64) @(negedge clk);
        chk("t4_idle", rx_busy, 0);
        chk("t4_fe_total", n_fe, fe0 + 1);

        bit_time(1'b0);
        for (int i = 0; i < 3; i++) bit_time(i[0] == 1'b0);
        rx = 1'b1;
        repeat (32) @(negedge clk);
        chk("t5_busy_mid", rx_busy, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_busy", rx_busy, 0);
        chk("t5_rst_data", rx_data, 0);
        repeat (128) @(negedge clk);
        chk("t5_no_valid", n_valid, v0);
        send(8'h81, 1'b1, 1'b0);
        repeat (64) @(negedge clk);
        chk("t5_valid_cnt", n_valid, v0 + 1);
        chk("t5_data", rx_data, 8'h81);

        for (int k = 0; k < 4; k++) send(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        repeat (64) @(negedge clk);
        chk("rnd_valid_cnt", n_valid, v0 + 5);

`ifdef UART_PARITY_EN
        send(8'h07, 1'b1, 1'b0);
        send(8'h07, 1'b1, 1'b1);
        repeat (64) @(negedge clk);
        chk("t6_valid_cnt", n_valid, v0 + 7);
`endif

        chk("sb_drained", q.size(), 0);
        chk("fe_final", n_fe, fe0 + 1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
